// File: rtl/period_meter_pkg.sv
// Shared FSM state type and default sizing for the period meter.
package period_meter_pkg;

   localparam int          DEF_CNT_W   = 32;
   localparam int unsigned DEF_TIMEOUT = 50_000_000;

   typedef enum logic [1:0] {
      WAIT_EDGE = 2'd0,
      COUNT     = 2'd1,
      HOLD      = 2'd2
   } state_t;

endpackage

// File: rtl/period_meter_if.sv
// Result handshake bundle: the meter drives the result, the consumer drives ready.
interface period_meter_if
   import period_meter_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) ();

   logic             meas_valid;
   logic             meas_ready;
   logic [CNT_W-1:0] meas_period;
   logic [CNT_W-1:0] meas_high;
   logic             meas_timeout;

   modport master (
      output meas_valid,
      input  meas_ready,
      output meas_period,
      output meas_high,
      output meas_timeout
   );

   modport slave (
      input  meas_valid,
      output meas_ready,
      input  meas_period,
      input  meas_high,
      input  meas_timeout
   );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input followed by a rise/fall detector.
module sync_edge (
   input  logic clk,
   input  logic srst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   // [0],[1] synchronise; [2] holds the previous synchronised level
   logic [2:0] sync_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[1:0], din};
      end
   end

   assign level = sync_reg[1];
   assign rise  = sync_reg[1] & ~sync_reg[2];
   assign fall  = ~sync_reg[1] & sync_reg[2];

endmodule

// File: rtl/period_meter.sv
// Measures the rising-edge period (and optionally high time) of an async input.
// Define PERIOD_METER_HIGH_TIME_EN to build the high-time counter; otherwise meas_high reads 0.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int          CNT_W   = DEF_CNT_W,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           en,
   input  logic           sig_in,
   period_meter_if.master bus
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] period_reg;
   logic             timeout_reg;
   logic             valid_reg;

   logic level, rise, fall;
   logic at_limit, start, capture;

   sync_edge u_sync (
      .clk   (CLK),
      .srst  (RST),
      .din   (sig_in),
      .level (level),
      .rise  (rise),
      .fall  (fall)
   );

   // start: a rising edge opens a new period; capture: the open period closes
   assign at_limit = (cnt_reg == TIMEOUT_C);
   assign start    = en && rise &&
                     ((state_reg == WAIT_EDGE) || ((state_reg == HOLD) && bus.meas_ready));
   assign capture  = en && (state_reg == COUNT) && (rise || at_limit);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg   <= WAIT_EDGE;
         cnt_reg     <= '0;
         period_reg  <= '0;
         timeout_reg <= 1'b0;
         valid_reg   <= 1'b0;
      end else if (!en) begin
         state_reg <= WAIT_EDGE;
         cnt_reg   <= '0;
         valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            WAIT_EDGE: begin
               if (start) begin
                  state_reg <= COUNT;
                  cnt_reg   <= ONE;
               end
            end
            COUNT: begin
               // cnt equals TIMEOUT on a timeout, so cnt is the result either way
               if (capture) begin
                  period_reg  <= cnt_reg;
                  timeout_reg <= !rise;
                  valid_reg   <= 1'b1;
                  state_reg   <= HOLD;
               end else begin
                  cnt_reg <= cnt_reg + ONE;
               end
            end
            HOLD: begin
               if (bus.meas_ready) begin
                  valid_reg <= 1'b0;
                  if (start) begin
                     state_reg <= COUNT;
                     cnt_reg   <= ONE;
                  end else begin
                     state_reg <= WAIT_EDGE;
                  end
               end
            end
            default: begin
               state_reg <= WAIT_EDGE;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

`ifdef PERIOD_METER_HIGH_TIME_EN
   logic [CNT_W-1:0] high_cnt_reg;
   logic [CNT_W-1:0] high_reg;
   logic             fell_reg;

   // high time counts only the first high phase after the opening edge
   always_ff @(posedge CLK) begin
      if (RST) begin
         high_cnt_reg <= '0;
         high_reg     <= '0;
         fell_reg     <= 1'b0;
      end else if (en) begin
         if (start) begin
            high_cnt_reg <= ONE;
            fell_reg     <= 1'b0;
         end else if ((state_reg == COUNT) && !capture) begin
            if (fall) begin
               fell_reg <= 1'b1;
            end
            if (level && !fell_reg) begin
               high_cnt_reg <= high_cnt_reg + ONE;
            end
         end
         if (capture) begin
            high_reg <= high_cnt_reg;
         end
      end
   end

   assign bus.meas_high = high_reg;
`else
   logic unused_sync;
   assign unused_sync   = &{1'b0, fall, level};
   assign bus.meas_high = '0;
`endif

   assign bus.meas_valid   = valid_reg;
   assign bus.meas_period  = period_reg;
   assign bus.meas_timeout = timeout_reg;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a TIMEOUT=100 meter and a TIMEOUT=10 meter share the stimulus.
module tb_period_meter;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic sig_in;

   int  tests_run    = 0;
   int  tests_failed = 0;

   // square-wave generator controls
   bit   gen_run   = 1'b0;
   logic gen_level = 1'b0;
   logic gen_wave  = 1'b0;
   int   gen_per   = 10;
   int   gen_hi    = 5;
   int   gp, gh;

   typedef struct {
      int per;
      int hi;
      int exp_per;
      int exp_hi;
      int b_per;
      bit b_to;
   } vec_t;

   vec_t vecs [4];

   period_meter_if #(.CNT_W(32)) bus_a ();
   period_meter_if #(.CNT_W(32)) bus_b ();

   period_meter #(.CNT_W(32), .TIMEOUT(100)) dut (
      .CLK    (clk),
      .RST    (rst),
      .en     (en),
      .sig_in (sig_in),
      .bus    (bus_a)
   );

   period_meter #(.CNT_W(32), .TIMEOUT(10)) dut_t10 (
      .CLK    (clk),
      .RST    (rst),
      .en     (en),
      .sig_in (sig_in),
      .bus    (bus_b)
   );

   always #10 clk = ~clk;

   assign sig_in = gen_run ? gen_wave : gen_level;

   initial begin
      forever begin
         if (gen_run) begin
            gp = gen_per;
            gh = gen_hi;
            for (int i = 0; i < gp; i++) begin
               gen_wave = (i < gh);
               @(negedge clk);
            end
         end else begin
            @(negedge clk);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   function automatic int exp_high(input int hi);
`ifdef PERIOD_METER_HIGH_TIME_EN
      return hi;
`else
      return 0 * hi;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end else begin
         $display("ok   %s: %0d", name, got);
      end
   endtask

   task automatic wait_valid(input bit sel_b, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((sel_b ? bus_b.meas_valid : bus_a.meas_valid) === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic idle_wave(input int per, input int hi);
      en      = 1'b0;
      gen_per = per;
      gen_hi  = hi;
      gen_run = 1'b1;
      repeat (60) @(negedge clk);
      en = 1'b1;
   endtask

   // drop en (or pulse RST) when cnt has reached 4, then keep a 10-cycle wave going
   task automatic abort_run(input bit use_rst);
      int first;
      logic [31:0] per;
      en        = 1'b0;
      gen_run   = 1'b0;
      gen_level = 1'b0;
      bus_a.meas_ready = 1'b1;
      repeat (10) @(negedge clk);
      en    = 1'b1;
      first = -1;
      per   = '0;
      for (int c = 0; c < 40; c++) begin
         gen_level = ((c % 10) < 5);
         if (c == 6) begin
            if (use_rst) rst = 1'b1;
            else         en  = 1'b0;
         end
         if (c == 7) begin
            rst = 1'b0;
            en  = 1'b1;
         end
         @(negedge clk);
         if (bus_a.meas_valid === 1'b1 && first < 0) begin
            first = c;
            per   = bus_a.meas_period;
         end
      end
      check(use_rst ? "abort_rst_first_valid_cycle" : "abort_en_first_valid_cycle", first, 22);
      check(use_rst ? "abort_rst_period" : "abort_en_period", per, 10);
   endtask

   initial begin
      bit ok;
      int n_a, n_b, bad;
      logic [31:0] p_a, p_b;
      logic        t_a, t_b;
      logic [96:0] snap;

      vecs[0] = '{10,  5, 10, exp_high(5),  10, 1'b0};
      vecs[1] = '{ 7,  3,  7, exp_high(3),   7, 1'b0};
      vecs[2] = '{16,  1, 16, exp_high(1),  10, 1'b1};
      vecs[3] = '{25, 20, 25, exp_high(20), 10, 1'b1};

      rst = 1'b1;
      en  = 1'b1;
      bus_a.meas_ready = 1'b1;
      bus_b.meas_ready = 1'b1;
      gen_per = 10;
      gen_hi  = 5;
      gen_run = 1'b1;

      // reset held with the input toggling: everything stays zero
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("reset_outputs_cycle%0d", i),
               {bus_a.meas_valid, bus_a.meas_period, bus_a.meas_high, bus_a.meas_timeout}, '0);
      end
      rst = 1'b0;

      foreach (vecs[v]) begin
         idle_wave(vecs[v].per, vecs[v].hi);
         wait_valid(1'b0, 100, ok);
         check($sformatf("v%0d_a_valid_seen", v), ok, 1);
         if (ok) begin
            check($sformatf("v%0d_a_period", v), bus_a.meas_period, vecs[v].exp_per);
            check($sformatf("v%0d_a_high", v), bus_a.meas_high, vecs[v].exp_hi);
            check($sformatf("v%0d_a_timeout", v), bus_a.meas_timeout, 0);
         end
         wait_valid(1'b1, 100, ok);
         check($sformatf("v%0d_b_valid_seen", v), ok, 1);
         if (ok) begin
            check($sformatf("v%0d_b_period", v), bus_b.meas_period, vecs[v].b_per);
            check($sformatf("v%0d_b_timeout", v), bus_b.meas_timeout, vecs[v].b_to);
         end
      end

      // single rising edge then constant high: one timeout result per meter
      en        = 1'b0;
      gen_run   = 1'b0;
      gen_level = 1'b0;
      repeat (10) @(negedge clk);
      en        = 1'b1;
      gen_level = 1'b1;
      n_a = 0; n_b = 0;
      p_a = '0; p_b = '0; t_a = 1'b0; t_b = 1'b0;
      for (int i = 0; i < 250; i++) begin
         @(negedge clk);
         if (bus_a.meas_valid === 1'b1) begin
            n_a++;
            p_a = bus_a.meas_period;
            t_a = bus_a.meas_timeout;
         end
         if (bus_b.meas_valid === 1'b1) begin
            n_b++;
            p_b = bus_b.meas_period;
            t_b = bus_b.meas_timeout;
         end
      end
      check("timeout100_valid_count", n_a, 1);
      check("timeout100_period", p_a, 100);
      check("timeout100_flag", t_a, 1);
      check("timeout10_valid_count", n_b, 1);
      check("timeout10_period", p_b, 10);
      check("timeout10_flag", t_b, 1);

      // consumer stalls for 30 cycles: result must be held unchanged
      bus_a.meas_ready = 1'b0;
      idle_wave(10, 5);
      wait_valid(1'b0, 100, ok);
      check("bp_valid_seen", ok, 1);
      check("bp_first_period", bus_a.meas_period, 10);
      snap = {bus_a.meas_valid, bus_a.meas_period, bus_a.meas_high, bus_a.meas_timeout};
      bad  = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if ({bus_a.meas_valid, bus_a.meas_period, bus_a.meas_high, bus_a.meas_timeout} !== snap)
            bad++;
      end
      check("bp_unstable_cycles", bad, 0);
      bus_a.meas_ready = 1'b1;
      @(negedge clk);
      bus_a.meas_ready = 1'b0;
      check("bp_valid_after_handshake", bus_a.meas_valid, 0);
      wait_valid(1'b0, 100, ok);
      check("bp_next_valid_seen", ok, 1);
      check("bp_next_period", bus_a.meas_period, 10);
      bus_a.meas_ready = 1'b1;

      abort_run(1'b0);
      abort_run(1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
